// File: rtl/dram_readback_unit_pkg.sv
// Shared definitions for the DRAM readback unit: default geometry and FSM state encoding.
// Ports: none (package).
// Imported by dram_readback_unit and its testbench.
package dram_readback_unit_pkg;

  localparam int DEF_ADDR_W     = 9;
  localparam int DEF_DATA_W     = 16;
  localparam int DEF_RD_LAT     = 2;
  localparam int DEF_FIFO_DEPTH = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/dram_readback_unit_rd_skid_fifo.sv
// Synchronous FIFO holding returned {data, addr} entries; one push and one pop per cycle.
// Latency: pushed entry visible at o_dat the cycle after push. Backpressure: push while full
// without a pop is dropped (the caller's credit logic never does that); flush empties it.
// Ports: i_push/i_push_dat write side, i_pop read side, i_flush, o_dat head, o_count, o_empty.
module rd_skid_fifo #(
  parameter int WIDTH = 25,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_dat,
  input  logic             i_pop,
  input  logic             i_flush,
  output logic [WIDTH-1:0] o_dat,
  output logic [CW-1:0]    o_count,
  output logic             o_empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_full;
  logic             w_do_push;
  logic             w_do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign w_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign w_do_pop  = i_pop && !o_empty;
  // A full FIFO may still accept a push when the head leaves in the same cycle.
  assign w_do_push = i_push && (!w_full || w_do_pop);
  assign o_dat     = r_mem[r_rd_ptr];
  assign o_count   = r_count;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= i_push_dat;
        r_wr_ptr        <= ptr_inc(r_wr_ptr);
      end
      if (w_do_pop) r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/dram_readback_unit.sv
// Streams word_count consecutive DRAM words from base_addr out as {data, addr} on a valid/ready port.
// Latency: first out_valid RD_LAT+1 cycles after entering ISSUE. Backpressure: reads are issued only
// while in-flight reads plus buffered words fit in the FIFO, so out_ready low stalls issue, never drops.
// Ports: i_start/i_abort/i_base_addr/i_word_count control, o_mem_* / i_mem_rdata DRAM read port,
// o_out_* / i_out_ready output stream, o_busy, o_done.
module dram_readback_unit
  import dram_readback_unit_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int RD_LAT     = DEF_RD_LAT,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_abort,
  input  logic [ADDR_W-1:0] i_base_addr,
  input  logic [ADDR_W:0]   i_word_count,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic              o_mem_rd_en,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic [DATA_W-1:0] o_out_data,
  output logic [ADDR_W-1:0] o_out_addr,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic              o_busy,
  output logic              o_done
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int SW = $clog2(FIFO_DEPTH + RD_LAT + 1) + 1;
  localparam int EW = DATA_W + ADDR_W;

  state_t            r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W:0]   r_issue_rem;
  logic [ADDR_W:0]   r_accept_rem;
  logic              r_busy;
  logic              r_done;
  logic [RD_LAT-1:0] r_lat_vld;
  logic [ADDR_W-1:0] r_lat_addr [RD_LAT];

  logic [CW-1:0]     w_fifo_count;
  logic              w_fifo_empty;
  logic [EW-1:0]     w_fifo_dat;
  logic              w_push;
  logic              w_pop;
  logic              w_issue;
  logic [SW-1:0]     w_used;

  // The oldest latency stage lines up with the DRAM data for that read.
  assign w_push = r_lat_vld[RD_LAT-1];
  assign w_pop  = !w_fifo_empty && i_out_ready;

  // Credit in use next cycle before any new issue: buffered + in flight - leaving now.
  // A pop implies a non-empty FIFO, so this cannot underflow.
  always_comb begin
    w_used = SW'(w_fifo_count) - SW'(w_pop);
    for (int i = 0; i < RD_LAT; i++) w_used = w_used + SW'(r_lat_vld[i]);
  end

  assign w_issue = (r_state == S_ISSUE) && !i_abort && (w_used < SW'(FIFO_DEPTH));

  rd_skid_fifo #(
    .WIDTH(EW),
    .DEPTH(FIFO_DEPTH),
    .CW   (CW)
  ) u_fifo (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_push    (w_push),
    .i_push_dat({i_mem_rdata, r_lat_addr[RD_LAT-1]}),
    .i_pop     (w_pop),
    .i_flush   (i_abort),
    .o_dat     (w_fifo_dat),
    .o_count   (w_fifo_count),
    .o_empty   (w_fifo_empty)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= S_IDLE;
      r_addr       <= '0;
      r_issue_rem  <= '0;
      r_accept_rem <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_lat_vld    <= '0;
      for (int i = 0; i < RD_LAT; i++) r_lat_addr[i] <= '0;
    end else begin
      r_lat_vld[0]  <= w_issue;
      r_lat_addr[0] <= r_addr;
      for (int i = 1; i < RD_LAT; i++) begin
        r_lat_vld[i]  <= r_lat_vld[i-1];
        r_lat_addr[i] <= r_lat_addr[i-1];
      end
      r_done <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_addr       <= i_base_addr;
            r_issue_rem  <= i_word_count;
            r_accept_rem <= i_word_count;
            if (i_word_count == '0) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_ISSUE;
              r_busy  <= 1'b1;
            end
          end
        end
        S_ISSUE: begin
          // Address wraps naturally at 2**ADDR_W.
          if (w_issue) begin
            r_addr      <= r_addr + 1'b1;
            r_issue_rem <= r_issue_rem - 1'b1;
            if (r_issue_rem == (ADDR_W+1)'(1)) r_state <= S_DRAIN;
          end
          // The last word can never be accepted while reads are still pending.
          if (w_pop) r_accept_rem <= r_accept_rem - 1'b1;
        end
        S_DRAIN: begin
          if (w_pop) begin
            r_accept_rem <= r_accept_rem - 1'b1;
            if (r_accept_rem == (ADDR_W+1)'(1)) begin
              r_state <= S_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase

      // Abort overrides everything: returns still in the pipe are dropped, no done pulse.
      if (i_abort) begin
        r_state   <= S_IDLE;
        r_busy    <= 1'b0;
        r_done    <= 1'b0;
        r_lat_vld <= '0;
      end
    end
  end

  assign o_mem_addr  = r_addr;
  assign o_mem_rd_en = w_issue;
  assign o_out_data  = w_fifo_dat[EW-1 -: DATA_W];
  assign o_out_addr  = w_fifo_dat[ADDR_W-1:0];
  assign o_out_valid = !w_fifo_empty;
  assign o_busy      = r_busy;
  assign o_done      = r_done;

endmodule

// File: tb/tb_dram_readback_unit.sv
// Testbench for dram_readback_unit: DRAM model with registered read, scoreboard of expected words,
// and a free-running monitor that compares every accepted word and the stream/credit invariants.
module tb_dram_readback_unit;
  import dram_readback_unit_pkg::*;

  localparam int AW    = 9;
  localparam int DW    = 16;
  localparam int LAT   = 2;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start, abort;
  logic [AW-1:0] base_addr;
  logic [AW:0]   word_count;
  logic [AW-1:0] mem_addr;
  logic          mem_rd_en;
  logic [DW-1:0] mem_rdata;
  logic [DW-1:0] out_data;
  logic [AW-1:0] out_addr;
  logic          out_valid, out_ready, busy, done;

  always #5 clk = ~clk;

  dram_readback_unit #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(LAT), .FIFO_DEPTH(DEPTH)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_abort(abort),
    .i_base_addr(base_addr), .i_word_count(word_count),
    .o_mem_addr(mem_addr), .o_mem_rd_en(mem_rd_en), .i_mem_rdata(mem_rdata),
    .o_out_data(out_data), .o_out_addr(out_addr), .o_out_valid(out_valid),
    .i_out_ready(out_ready), .o_busy(busy), .o_done(done)
  );

  // DRAM model: contents a ^ 16'hA5A5, LAT-stage registered read.
  logic [DW-1:0] dram [512];
  logic [DW-1:0] rd_pipe [LAT];
  initial for (int i = 0; i < 512; i++) dram[i] = DW'(i) ^ 16'hA5A5;
  always @(posedge clk) begin
    rd_pipe[0] <= dram[mem_addr];
    for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign mem_rdata = rd_pipe[LAT-1];

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  exp_t hold_val;
  bit   hold_pend;
  bit   busy_seen;
  int   n_checks = 0, n_fail = 0;
  int   cyc = 0;
  int   n_rd, n_acc, n_done;
  int   start_cyc, acc_first, acc_last, done_cyc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: samples 2 time units after the falling edge, i.e. well before the next rising edge.
  initial forever begin
    @(negedge clk);
    #2;
    cyc++;
    if (rst_n) begin
      if (start && !abort && !busy && !done) start_cyc = cyc;
      if (hold_pend) check("hold_stable", {out_valid, out_addr, out_data}, {1'b1, hold_val});
      hold_pend = out_valid && !out_ready;
      hold_val  = {out_addr, out_data};
      if (mem_rd_en) n_rd++;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_word: got addr %0h data %0h, expected none", out_addr, out_data);
        end else begin
          mon_e = exp_q.pop_front();
          check("word_addr", out_addr, mon_e.a);
          check("word_data", out_data, mon_e.d);
        end
        n_acc++;
        if (acc_first < 0) acc_first = cyc;
        acc_last = cyc;
      end
      // Reads issued but not yet accepted must fit in the FIFO.
      if (mem_rd_en) check("credit", (n_rd - n_acc) <= DEPTH, 1);
      if (busy) busy_seen = 1;
      if (done) begin
        n_done++;
        done_cyc = cyc;
        check("done_not_busy", busy, 0);
      end
    end
  end

  function automatic logic ready_for(input int mode, input int t);
    case (mode)
      0:       return 1'b1;
      1:       return (t % 2) == 0;
      default: return 1'($urandom_range(0, 1));
    endcase
  endfunction

  task automatic clear_stats();
    n_rd = 0; n_acc = 0; n_done = 0; busy_seen = 0;
    acc_first = -1; acc_last = -1; done_cyc = -1; start_cyc = -1;
  endtask

  // One readback: model pushes expected words, then start is pulsed and the run is bounded.
  task automatic run_read(input int base, input int cnt, input int mode, input bit timing_chk,
                          input bit restart);
    int a;
    for (int k = 0; k < cnt; k++) begin
      a = (base + k) % 512;
      exp_q.push_back({AW'(a), DW'(a) ^ 16'hA5A5});
    end
    clear_stats();
    @(negedge clk);
    base_addr  = AW'(base);
    word_count = (AW+1)'(cnt);
    start      = 1'b1;
    out_ready  = ready_for(mode, 0);
    @(negedge clk);
    start = 1'b0;
    for (int t = 1; t < 6 * cnt + 40 && n_done == 0; t++) begin
      out_ready = ready_for(mode, t);
      if (restart && t == 2) begin
        start = 1'b1; base_addr = '0; word_count = 1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start     = 1'b0;
    out_ready = 1'b1;
    repeat (4) @(negedge clk);
    check("done_count", n_done, 1);
    check("reads_issued", n_rd, cnt);
    check("queue_empty", exp_q.size(), 0);
    check("busy_seen", busy_seen, cnt != 0);
    if (cnt == 0) check("zero_done_latency", done_cyc - start_cyc, 1);
    if (timing_chk && cnt > 0) begin
      check("first_latency", acc_first - start_cyc, LAT + 2);
      check("back_to_back", acc_last - acc_first, cnt - 1);
      check("done_after_last", done_cyc - acc_last, 1);
    end
    exp_q.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_mem_addr"}, mem_addr, 0);
    check({tag, "_mem_rd_en"}, mem_rd_en, 0);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_out_data"}, out_data, 0);
    check({tag, "_out_addr"}, out_addr, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
    base_addr = '0; word_count = '0; hold_pend = 0;
    clear_stats();
    #12;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // T1: basic streaming at full rate with exact timing.
    run_read(1, 4, 0, 1, 0);
    // T2: out_ready toggling every cycle.
    run_read(0, 8, 1, 0, 0);
    // T3: wrap 511 -> 0, plus a start while busy that must be ignored.
    run_read(510, 4, 0, 1, 1);
    // T4: zero-length readback.
    run_read(0, 0, 0, 0, 0);

    // T5: stall with out_ready low, abort mid-run, then a fresh readback.
    clear_stats();
    @(negedge clk);
    base_addr = '0; word_count = 16; start = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    check("stall_reads", n_rd, DEPTH);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    hold_pend = 0;
    n_rd = 0; n_acc = 0;
    #2;
    check("abort_out_valid", out_valid, 0);
    check("abort_busy", busy, 0);
    repeat (10) @(negedge clk);
    check("abort_no_done", n_done, 0);
    check("abort_no_reads", n_rd, 0);
    run_read(5, 1, 0, 0, 0);

    // T6: asynchronous reset after three words of a ten-word readback.
    for (int k = 0; k < 10; k++) exp_q.push_back({AW'(20 + k), DW'(20 + k) ^ 16'hA5A5});
    clear_stats();
    @(negedge clk);
    base_addr = 20; word_count = 10; start = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int t = 0; t < 40 && n_acc < 3; t++) @(negedge clk);
    check("pre_reset_words", n_acc, 3);
    #1 rst_n = 1'b0;
    #1;
    check_reset_outputs("midrun_reset");
    exp_q.delete();
    hold_pend = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_read(200, 6, 2, 0, 0);

    // Randomized readbacks with random backpressure.
    for (int r = 0; r < 6; r++)
      run_read(int'($urandom_range(0, 511)), int'($urandom_range(1, 24)), 2, 0, 0);

    // Full-memory wrap: every address exactly once, full rate.
    run_read(300, 512, 0, 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
